// File: rtl/pattern_log_pkg.sv
// Shared widths, constants and log entry type for the pattern event logger.
// Optional o_total counter is enabled by defining PATTERN_LOG_TOTAL_EN.
package pattern_log_pkg;

  localparam int PL_TS_WIDTH = 6;
  localparam int PL_TOTAL_W  = 16;
  localparam logic [PL_TOTAL_W-1:0] PL_TOTAL_SAT = '1;

  typedef struct packed {
    logic                   wrap;
    logic [PL_TS_WIDTH-1:0] ts;
  } log_entry_t;

endpackage

// File: rtl/pattern_log_fifo.sv
// Synchronous FIFO holding logged entries; caller never pushes when full
// without a same-cycle pop, and never pops when empty.
module pattern_log_fifo
  import pattern_log_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PL_TS_WIDTH + 1
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; the top masks the head while empty.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_level = level_q;
  assign o_full  = (level_q == LW'(DEPTH));
  assign o_empty = (level_q == '0);

endmodule

// File: rtl/pattern_event_logger.sv
// Logs timestamped pattern matches with wrap flag, overflow and match count.
// o_total is a live counter only when PATTERN_LOG_TOTAL_EN is defined.
module pattern_event_logger
  import pattern_log_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = PL_TS_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_pattern_found,
  input  logic [TS_WIDTH-1:0]        i_count,
  input  logic                       i_count_end,
  input  logic                       i_clear,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [TS_WIDTH-1:0]        o_timestamp,
  output logic                       o_wrap,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic [PL_TOTAL_W-1:0]      o_total
);

  localparam int EW = TS_WIDTH + 1;

  logic          wrap_q, wrap_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign pop  = o_valid & i_ready & ~i_clear;
  assign push = i_pattern_found & ~i_clear & (~o_full | pop);

  pattern_log_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clear  (i_clear),
    .i_push   (push),
    .i_pop    (pop),
    .i_data   ({wrap_q, i_count}),
    .o_data   (head),
    .o_level  (o_level),
    .o_full   (o_full),
    .o_empty  (o_empty)
  );

  assign o_valid     = ~o_empty;
  assign o_wrap      = o_valid & head[TS_WIDTH];
  assign o_timestamp = o_valid ? head[TS_WIDTH-1:0] : '0;
  assign o_overflow  = ovf_q;

  always_comb begin
    wrap_d = wrap_q;
    ovf_d  = ovf_q;
    if (i_clear) begin
      wrap_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      wrap_d = i_pattern_found ? i_count_end : (wrap_q | i_count_end);
      if (i_pattern_found && o_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef PATTERN_LOG_TOTAL_EN
  logic [PL_TOTAL_W-1:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (i_clear) total_d = '0;
    else if (i_pattern_found && total_q != PL_TOTAL_SAT)
      total_d = total_q + PL_TOTAL_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) total_q <= '0;
    else           total_q <= total_d;
  end

  assign o_total = total_q;
`else
  assign o_total = '0;
`endif

endmodule

// File: tb/tb_pattern_event_logger.sv
// Self-checking bench for pattern_event_logger (DEPTH=4, TS_WIDTH=6).
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_pattern_event_logger;
  import pattern_log_pkg::*;

  localparam int DEPTH = 4;
  localparam int TSW   = 6;
  localparam int LW    = $clog2(DEPTH+1);

  logic           i_clk = 1'b0;
  logic           i_resetn = 1'b0;
  logic           i_pattern_found = 1'b0;
  logic [TSW-1:0] i_count = '0;
  logic           i_count_end = 1'b0;
  logic           i_clear = 1'b0;
  logic           i_ready = 1'b0;
  logic           o_valid, o_wrap, o_full, o_empty, o_overflow;
  logic [TSW-1:0] o_timestamp;
  logic [LW-1:0]  o_level;
  logic [15:0]    o_total;

  int checks = 0;
  int errors = 0;

  log_entry_t mq[$];
  bit m_wrap, m_ovf;
  int m_total;

  pattern_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .i_pattern_found(i_pattern_found), .i_count(i_count),
    .i_count_end(i_count_end), .i_clear(i_clear),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_timestamp(o_timestamp), .o_wrap(o_wrap),
    .o_level(o_level), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_total(o_total)
  );

  always #5 i_clk = ~i_clk;

  function automatic int exp_total(int raw);
`ifdef PATTERN_LOG_TOTAL_EN
    return raw;
`else
    return 0 * raw;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_wrap = 0; m_ovf = 0; m_total = 0;
  endfunction

  // Behaviour at one rising edge, stated as log rules on a queue.
  function automatic void model_edge(bit f, logic [TSW-1:0] c,
                                     bit e, bit clr, bit rdy);
    log_entry_t ent;
    if (clr) begin
      model_reset();
      return;
    end
    ent.wrap = m_wrap;
    ent.ts   = c;
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    if (f) begin
      if (m_total < 65535) m_total++;
      if (mq.size() >= DEPTH) m_ovf = 1;
      else mq.push_back(ent);
    end
    m_wrap = f ? e : (m_wrap | e);
  endfunction

  task automatic cycle(input bit f, input logic [TSW-1:0] c,
                       input bit e, input bit clr, input bit rdy);
    i_pattern_found = f; i_count = c; i_count_end = e;
    i_clear = clr; i_ready = rdy;
    @(posedge i_clk);
    model_edge(f, c, e, clr, rdy);
    #1;
    i_pattern_found = 0; i_clear = 0; i_ready = 0; i_count_end = 0;
  endtask

  task automatic test_reset();
    i_resetn = 0;
    #3;
    checks++;
    if ({o_valid, o_empty, o_full, o_overflow, o_wrap} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=01000",
               {o_valid, o_empty, o_full, o_overflow, o_wrap});
    end
    checks++;
    if (o_level !== '0 || o_timestamp !== '0 || o_total !== '0) begin
      errors++;
      $display("FAIL reset_vals lvl=%0d ts=%0d tot=%0d exp 0/0/0",
               o_level, o_timestamp, o_total);
    end
    model_reset();
    @(negedge i_clk);
    i_resetn = 1;
  endtask

  task automatic test_first_capture();
    cycle(1, 6'd5, 0, 0, 0);
    checks++;
    if (o_valid !== 1 || o_timestamp !== 6'd5 || o_wrap !== 0
        || o_level !== 3'd1) begin
      errors++;
      $display("FAIL first_cap v=%b ts=%0d w=%b lvl=%0d exp 1/5/0/1",
               o_valid, o_timestamp, o_wrap, o_level);
    end
    cycle(0, 6'd6, 0, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) cycle(1, TSW'(10*i), 0, 0, 0);
    checks++;
    if (o_level !== 3'd4 || o_full !== 1 || o_overflow !== 1) begin
      errors++;
      $display("FAIL ovf_state lvl=%0d full=%b ovf=%b exp 4/1/1",
               o_level, o_full, o_overflow);
    end
    checks++;
    if (o_total !== 16'(exp_total(5))) begin
      errors++;
      $display("FAIL ovf_total got=%0d exp=%0d", o_total, exp_total(5));
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (o_valid !== 1 || o_timestamp !== TSW'(10*i)) begin
        errors++;
        $display("FAIL drain_%0d v=%b ts=%0d exp ts=%0d",
                 i, o_valid, o_timestamp, 10*i);
      end
      cycle(0, 6'd0, 0, 0, 1);
    end
    checks++;
    if (o_empty !== 1 || o_valid !== 0 || o_timestamp !== '0) begin
      errors++;
      $display("FAIL drain_empty e=%b v=%b ts=%0d exp 1/0/0",
               o_empty, o_valid, o_timestamp);
    end
    cycle(0, 6'd0, 0, 1, 0);
  endtask

  task automatic test_wrap();
    cycle(1, 6'd60, 0, 0, 0);
    cycle(0, 6'd61, 0, 0, 0);
    cycle(0, 6'd62, 0, 0, 0);
    cycle(0, 6'd63, 1, 0, 0);
    cycle(0, 6'd0, 0, 0, 0);
    cycle(0, 6'd1, 0, 0, 0);
    cycle(1, 6'd2, 0, 0, 0);
    checks++;
    if (o_timestamp !== 6'd60 || o_wrap !== 0 || o_level !== 3'd2) begin
      errors++;
      $display("FAIL wrap_head ts=%0d w=%b lvl=%0d exp 60/0/2",
               o_timestamp, o_wrap, o_level);
    end
    cycle(0, 6'd3, 0, 0, 1);
    checks++;
    if (o_timestamp !== 6'd2 || o_wrap !== 1) begin
      errors++;
      $display("FAIL wrap_second ts=%0d w=%b exp 2/1", o_timestamp, o_wrap);
    end
    cycle(0, 6'd4, 0, 0, 1);
    cycle(1, 6'd63, 1, 0, 0);
    checks++;
    if (o_timestamp !== 6'd63 || o_wrap !== 0) begin
      errors++;
      $display("FAIL wrap_at_end ts=%0d w=%b exp 63/0", o_timestamp, o_wrap);
    end
    cycle(1, 6'd5, 0, 0, 1);
    checks++;
    if (o_timestamp !== 6'd5 || o_wrap !== 1 || o_level !== 3'd1) begin
      errors++;
      $display("FAIL wrap_after_end ts=%0d w=%b lvl=%0d exp 5/1/1",
               o_timestamp, o_wrap, o_level);
    end
    cycle(0, 6'd0, 0, 1, 0);
  endtask

  task automatic test_full_pop();
    for (int i = 1; i <= 4; i++) cycle(1, TSW'(i), 0, 0, 0);
    cycle(1, 6'd9, 0, 0, 1);
    checks++;
    if (o_level !== 3'd4 || o_overflow !== 0 || o_timestamp !== 6'd2) begin
      errors++;
      $display("FAIL full_pop lvl=%0d ovf=%b ts=%0d exp 4/0/2",
               o_level, o_overflow, o_timestamp);
    end
    for (int i = 0; i < 3; i++) cycle(0, 6'd0, 0, 0, 1);
    checks++;
    if (o_timestamp !== 6'd9 || o_level !== 3'd1) begin
      errors++;
      $display("FAIL full_pop_tail ts=%0d lvl=%0d exp 9/1",
               o_timestamp, o_level);
    end
    cycle(0, 6'd0, 0, 1, 0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) cycle(1, TSW'(20+i), 0, 0, 0);
    cycle(1, 6'd7, 0, 1, 1);
    checks++;
    if (o_level !== '0 || o_valid !== 0 || o_overflow !== 0
        || o_total !== '0) begin
      errors++;
      $display("FAIL clear lvl=%0d v=%b ovf=%b tot=%0d exp 0/0/0/0",
               o_level, o_valid, o_overflow, o_total);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 6'd11, 0, 0, 0);
    cycle(1, 6'd12, 1, 0, 0);
    @(posedge i_clk);
    #3;
    i_resetn = 0;
    #1;
    checks++;
    if (o_valid !== 0 || o_empty !== 1 || o_level !== '0
        || o_timestamp !== '0 || o_wrap !== 0) begin
      errors++;
      $display("FAIL async_reset v=%b e=%b lvl=%0d ts=%0d exp 0/1/0/0",
               o_valid, o_empty, o_level, o_timestamp);
    end
    model_reset();
    #3;
    i_resetn = 1;
    cycle(1, 6'd33, 0, 0, 1);
    checks++;
    if (o_level !== 3'd1 || o_timestamp !== 6'd33 || o_wrap !== 0) begin
      errors++;
      $display("FAIL post_reset lvl=%0d ts=%0d w=%b exp 1/33/0",
               o_level, o_timestamp, o_wrap);
    end
    cycle(0, 6'd0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [TSW-1:0] cnt = '0;
    log_entry_t hd;
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), cnt, cnt == '1,
            $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      cnt = cnt + 1'b1;
      hd = (mq.size() != 0) ? mq[0] : '0;
      checks++;
      if (o_level !== LW'(mq.size()) || o_valid !== (mq.size() != 0)
          || o_full !== (mq.size() == DEPTH) || o_overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_state n=%0d lvl=%0d/%0d v=%b ovf=%b/%b",
                 n, o_level, mq.size(), o_valid, o_overflow, m_ovf);
      end
      checks++;
      if (o_timestamp !== hd.ts || o_wrap !== hd.wrap
          || o_total !== 16'(exp_total(m_total))) begin
        errors++;
        $display("FAIL rnd_head n=%0d ts=%0d/%0d w=%b/%b tot=%0d/%0d",
                 n, o_timestamp, hd.ts, o_wrap, hd.wrap,
                 o_total, exp_total(m_total));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_overflow();
    test_wrap();
    test_full_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_event_logger.md
PATTERN_EVENT_LOGGER -- requirements
Module: pattern_event_logger

Interface
REQ-001 Parameter DEPTH, default 4, log entries held (power of two, >=2).
REQ-002 Parameter TS_WIDTH, default 6, timestamp width; matches detector counter width.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 i_pattern_found  input  1  one-cycle match strobe from upstream sequence detector.
REQ-006 i_count  input  TS_WIDTH  free-running timestamp from upstream counter.
REQ-007 i_count_end  input  1  high when i_count is at max (timestamp about to wrap).
REQ-008 i_clear  input  1  synchronous clear of log, flags and statistics.
REQ-009 o_valid  output  1  head entry available.
REQ-010 i_ready  input  1  consumer accepts head entry.
REQ-011 o_timestamp  output  TS_WIDTH  head entry timestamp.
REQ-012 o_wrap  output  1  head entry flag: timestamp wrapped at least once since previous captured event.
REQ-013 o_level  output  clog2(DEPTH+1)  entries held.
REQ-014 o_full / o_empty  output  1 each  level==DEPTH / level==0.
REQ-015 o_overflow  output  1  sticky: a match was dropped.
REQ-016 o_total  output  16  saturating count of all matches seen (logged or dropped).

Function
REQ-017 Capture cycle = any cycle with i_pattern_found=1; entry written = {wrap_seen, i_count} sampled that cycle.
REQ-018 wrap_seen register: on capture cycle loads i_count_end; otherwise sets when i_count_end=1, holds otherwise.
REQ-019 Pop = o_valid & i_ready; removes head at clock edge; o_valid = !o_empty.
REQ-020 Captured entry appears at head (o_valid=1 if log was empty) exactly one cycle after capture cycle; no combinational path from i_pattern_found to outputs.
REQ-021 o_timestamp/o_wrap stable while o_valid=1 and i_ready=0.
REQ-022 Capture when full with no pop: entry dropped, log unchanged, o_overflow set next cycle.
REQ-023 Capture when full with simultaneous pop: head removed, new entry written at tail, level stays DEPTH, no overflow.
REQ-024 Capture when empty with i_ready=1: no pop (o_valid was 0); level becomes 1.
REQ-025 Pointers wrap modulo DEPTH; level never exceeds DEPTH or underflows.
REQ-026 o_total increments on every capture cycle including dropped ones; holds at 16'hFFFF.
REQ-027 i_clear=1 takes priority over capture and pop in the same cycle: level 0, o_overflow 0, wrap_seen 0, o_total 0 next cycle; that cycle's match is discarded.

Reset
REQ-028 i_resetn=0 asynchronously forces: level 0, pointers 0, o_valid 0, o_empty 1, o_full 0, o_overflow 0, wrap_seen 0, o_total 0, o_timestamp 0, o_wrap 0.
REQ-029 Reset mid-operation discards all held entries; no entry survives; first capture after release behaves as from empty.
REQ-030 Entry storage need not be reset; outputs SHALL read 0 while o_valid=0.

Configuration
REQ-031 Macro PATTERN_LOG_TOTAL_EN: when defined, o_total counter per REQ-026/027 is built.
REQ-032 Without PATTERN_LOG_TOTAL_EN, no counter flops exist and o_total is tied to 0; port list unchanged.

Structure
REQ-033 Package pattern_log_pkg holds TS_WIDTH default, total width (16), total saturation constant, and the log entry typedef {wrap, timestamp}.
REQ-034 Storage and pointers live in sub-module pattern_log_fifo (synchronous FIFO, push/pop/level/full/empty); top holds wrap tracking, overflow, total and clear logic.

Verification (DEPTH=4, TS_WIDTH=6)
REQ-035 Reset release, match at i_count=5, i_ready=0 -> next cycle o_valid=1, o_timestamp=5, o_wrap=0, o_level=1.
REQ-036 Matches at counts 10,20,30,40,50 with i_ready=0 -> level 4, o_full=1, o_overflow=1, o_total=5; drain yields 10,20,30,40.
REQ-037 Match at 60, counter wraps (i_count_end at 63), match at 2 -> second entry o_timestamp=2, o_wrap=1; match at 63 itself logs o_wrap=0.
REQ-038 Full log, match with o_valid=1 and i_ready=1 same cycle -> level stays 4, o_overflow=0, new entry at tail.
REQ-039 i_clear and i_pattern_found same cycle with 3 entries held -> next cycle level 0, o_valid=0, o_overflow=0, o_total=0.
REQ-040 i_resetn asserted with 2 entries held, mid-cycle -> outputs go to reset values immediately without clock edge.
